// File: rtl/irq_controller.sv
// irq_controller: samples, latches and masks peripheral interrupts toward CP0 HWInt
module irq_controller #(
  parameter int N_SRC = 6,
  parameter logic [N_SRC-1:0] MASK_RST = '0,
  parameter logic [N_SRC-1:0] MODE_RST = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [5:0]       HWInt,
  output logic             irq_valid,
  output logic [2:0]       irq_vec
);
  logic [N_SRC-1:0] mask, mode, pend, sync, prev, rise, clr, pend_nxt;
  logic [7:0] act;
  logic wr;
  logic unused;
  assign wr = sel & we;
  assign rise = sync & ~prev;
  assign clr = (wr && addr == 2'd2) ? wdata[N_SRC-1:0] : '0;
  assign pend_nxt = (mode & (rise | (pend & ~clr))) | (~mode & sync);
  assign act = 8'(pend & mask);
  assign HWInt = act[5:0];
  assign irq_valid = |HWInt;
  assign unused = ^{wdata[31:N_SRC], act[7:6]};
  // Lowest-numbered active line wins; scan downward so bit 0 is written last.
  always_comb begin
    irq_vec = 3'd0;
    for (int i = 5; i >= 0; i--) if (HWInt[i]) irq_vec = 3'(i);
  end
  // Combinational register read; shows pre-write state during a write cycle.
  always_comb begin
    rdata = !sel ? 32'd0 :
            addr == 2'd0 ? 32'(mask) :
            addr == 2'd1 ? 32'(mode) :
            addr == 2'd2 ? 32'(pend) :
            {irq_valid, 28'd0, irq_vec};
  end
  // Input sampling, pending latch and configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= MASK_RST;
      mode <= MODE_RST;
      pend <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      sync <= irq_src;
      prev <= sync;
      pend <= pend_nxt;
      if (wr && addr == 2'd0) mask <= wdata[N_SRC-1:0];
      if (wr && addr == 2'd1) mode <= wdata[N_SRC-1:0];
    end
  end
endmodule
